mem_access_unit: RTL and testbench

Sequencer between the IorD address mux and the 256-byte main memory of the multicycle MIPS datapath. Takes the selected address plus an access request from the control unit, runs the memory read/write cycles, performs read-modify-write for byte and halfword stores, and returns sign- or zero-extended load data with a one-cycle done pulse. Addresses outside 0–255 are rejected with an error flag for the exception logic.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access sequencer for the multicycle MIPS datapath: runs read, write and
// read-modify-write cycles against a 256-byte big-endian memory and extends load data.
module mem_access_unit #(
    parameter int ADDR_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        ld_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t      state, state_next;
    logic        we_q, we_next;
    logic [1:0]  size_q, size_next;
    logic        signed_q, signed_next;
    logic [15:0] wdata_q, wdata_next;

    logic [31:0] mem_addr_next;
    logic        mem_wr_next;
    logic [31:0] mem_wdata_next;
    logic [31:0] rdata_next;
    logic        done_next;
    logic        err_next;
    logic        busy_next;

    // Big-endian: the addressed byte sits in the top lane of the returned word.
    function automatic logic [31:0] load_ext(input logic [1:0]  sz,
                                              input logic        sgn,
                                              input logic [31:0] word);
        logic [31:0] result;
        case (sz)
            SZ_HALF: result = {{16{sgn & word[31]}}, word[31:16]};
            SZ_BYTE: result = {{24{sgn & word[31]}}, word[31:24]};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge_store(input logic [1:0]  sz,
                                                 input logic [15:0] wd,
                                                 input logic [31:0] old);
        logic [31:0] result;
        if (sz == SZ_BYTE) result = {wd[7:0], old[23:0]};
        else               result = {wd[15:0], old[15:0]};
        return result;
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        we_next        = we_q;
        size_next      = size_q;
        signed_next    = signed_q;
        wdata_next     = wdata_q;
        mem_addr_next  = mem_addr;
        mem_wr_next    = 1'b0;
        mem_wdata_next = mem_wdata;
        rdata_next     = rdata;
        done_next      = 1'b0;
        err_next       = err;

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    we_next     = we;
                    size_next   = size;
                    signed_next = ld_signed;
                    wdata_next  = wdata[15:0];
                    err_next    = 1'b0;
                    if (addr > 32'(ADDR_LIMIT)) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else if (we && size != SZ_HALF && size != SZ_BYTE) begin
                        state_next     = S_WRITE;
                        mem_addr_next  = addr;
                        mem_wr_next    = 1'b1;
                        mem_wdata_next = wdata;
                    end else begin
                        state_next    = S_READ;
                        mem_addr_next = addr;
                    end
                end
            end
            S_READ: state_next = S_WAIT;
            S_WAIT: begin
                if (we_q) begin
                    state_next     = S_WRITE;
                    mem_wr_next    = 1'b1;
                    mem_wdata_next = merge_store(size_q, wdata_q, mem_rdata);
                end else begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    rdata_next = load_ext(size_q, signed_q, mem_rdata);
                end
            end
            S_WRITE: begin
                state_next = S_DONE;
                done_next  = 1'b1;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            wdata_q   <= 16'h0;
            mem_addr  <= 32'h0;
            mem_wr    <= 1'b0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            we_q      <= we_next;
            size_q    <= size_next;
            signed_q  <= signed_next;
            wdata_q   <= wdata_next;
            mem_addr  <= mem_addr_next;
            mem_wr    <= mem_wr_next;
            mem_wdata <= mem_wdata_next;
            rdata     <= rdata_next;
            done      <= done_next;
            err       <= err_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-byte big-endian synchronous memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        ld_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.ADDR_LIMIT(255)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .ld_signed (ld_signed),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory: address sampled at the edge, data valid the next cycle.
    always @(posedge clk) begin
        logic [7:0] a;
        a = mem_addr[7:0];
        if (mem_wr) begin
            mem[a]        <= mem_wdata[31:24];
            mem[8'(a + 1)] <= mem_wdata[23:16];
            mem[8'(a + 2)] <= mem_wdata[15:8];
            mem[8'(a + 3)] <= mem_wdata[7:0];
        end
        mem_rdata <= {mem[a], mem[8'(a + 1)], mem[8'(a + 2)], mem[8'(a + 3)]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic put_word(input logic [7:0] a, input logic [31:0] v);
        mem[a]         = v[31:24];
        mem[8'(a + 1)] = v[23:16];
        mem[8'(a + 2)] = v[15:8];
        mem[8'(a + 3)] = v[7:0];
    endtask

    function automatic logic [31:0] get_word(input logic [7:0] a);
        return {mem[a], mem[8'(a + 1)], mem[8'(a + 2)], mem[8'(a + 3)]};
    endfunction

    // Issues one request and follows it to done (cycle numbers relative to the accept cycle),
    // then steps one more cycle into IDLE.
    task automatic run_op(input logic we_i, input logic [1:0] size_i, input logic sgn_i,
                          input logic [31:0] addr_i, input logic [31:0] wdata_i,
                          input logic hold_i,
                          output int done_cyc, output int wr_cyc, output int wr_cnt,
                          output logic [31:0] wr_data, output logic err_o, output int busy_bad);
        done_cyc = -1; wr_cyc = -1; wr_cnt = 0; wr_data = '0; err_o = 1'b0; busy_bad = 0;
        @(negedge clk);
        req = 1'b1; we = we_i; size = size_i; ld_signed = sgn_i; addr = addr_i; wdata = wdata_i;
        @(posedge clk);
        #1;
        if (!hold_i) req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (mem_wr) begin
                wr_cnt++;
                wr_cyc  = c;
                wr_data = mem_wdata;
            end
            if (!busy) busy_bad++;
            if (done) begin
                done_cyc = c;
                err_o    = err;
                break;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        if (mem_wr) wr_cnt++;
    endtask

    int          dc, wc, wn, bb;
    logic [31:0] wd;
    logic        eo;

    initial begin
        reset_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; ld_signed = 1'b0;
        addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", mem_addr | mem_wdata | rdata, 32'h0);
        check("reset_ctrl", {28'h0, mem_wr, done, err, busy}, 32'h0);
        reset_n = 1'b1;

        put_word(8'h10, 32'hDEADBEEF);
        run_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("lw_done_cycle", dc, 3);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_err", {31'h0, eo}, 32'h0);
        check("lw_no_write", wn, 0);
        check("lw_busy", bb, 0);
        check("lw_idle_after", {30'h0, busy, done}, 32'h0);

        put_word(8'h20, 32'h80123456);
        run_op(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("lb_done_cycle", dc, 3);
        check("lb_signed", rdata, 32'hFFFFFF80);
        run_op(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("lh_signed", rdata, 32'hFFFF8012);
        run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("lbu", rdata, 32'h00000080);

        put_word(8'h30, 32'h11223344);
        run_op(1'b1, 2'b10, 1'b0, 32'h30, 32'h000000AB, 1'b0, dc, wc, wn, wd, eo, bb);
        check("sb_wr_cycle", wc, 3);
        check("sb_wr_count", wn, 1);
        check("sb_wdata", wd, 32'hAB223344);
        check("sb_done_cycle", dc, 4);
        check("sb_busy", bb, 0);
        check("sb_mem", get_word(8'h30), 32'hAB223344);
        check("sb_rdata_kept", rdata, 32'h00000080);

        put_word(8'h40, 32'h11223344);
        run_op(1'b1, 2'b01, 1'b0, 32'h40, 32'h1234CAFE, 1'b0, dc, wc, wn, wd, eo, bb);
        check("sh_wdata", wd, 32'hCAFE3344);
        check("sh_done_cycle", dc, 4);

        run_op(1'b1, 2'b00, 1'b0, 32'h44, 32'h01020304, 1'b0, dc, wc, wn, wd, eo, bb);
        check("sw_wr_cycle", wc, 1);
        check("sw_done_cycle", dc, 2);
        check("sw_wdata", wd, 32'h01020304);
        check("sw_mem", get_word(8'h44), 32'h01020304);

        run_op(1'b0, 2'b00, 1'b0, 32'h00000100, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("oor_done_cycle", dc, 1);
        check("oor_err", {31'h0, eo}, 32'h1);
        check("oor_no_write", wn, 0);
        check("oor_rdata_kept", rdata, 32'h00000080);
        check("oor_addr_kept", mem_addr, 32'h44);

        mem[253] = 8'h0A; mem[254] = 8'h0B; mem[255] = 8'h0C; mem[0] = 8'h0D;
        run_op(1'b0, 2'b00, 1'b0, 32'd253, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("edge_err", {31'h0, eo}, 32'h0);
        check("edge_addr", mem_addr, 32'd253);
        check("edge_rdata", rdata, 32'h0A0B0C0D);

        // req kept high through the busy cycles must not restart the access
        put_word(8'h50, 32'h55AA55AA);
        run_op(1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 1'b1, dc, wc, wn, wd, eo, bb);
        check("hold_done_cycle", dc, 3);
        check("hold_rdata", rdata, 32'h55AA55AA);
        check("hold_idle_after", {30'h0, busy, done}, 32'h0);

        // Reset in the WAIT cycle of a byte store
        put_word(8'h60, 32'h11223344);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; ld_signed = 1'b0; addr = 32'h60; wdata = 32'hEE;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_wait_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_mid_data", mem_addr | mem_wdata | rdata, 32'h0);
        check("rst_mid_ctrl", {28'h0, mem_wr, done, err, busy}, 32'h0);
        wn = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_wr || busy) wn++;
            @(posedge clk);
            #1;
        end
        check("rst_no_activity", wn, 0);
        check("rst_mem_intact", get_word(8'h60), 32'h11223344);

        run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, dc, wc, wn, wd, eo, bb);
        check("post_rst_done_cycle", dc, 3);
        check("post_rst_rdata", rdata, 32'h00000080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
